// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: receiver state encoding
// and the bit-period calculation.
package serial_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq_hz,
                                                 input int unsigned baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Byte FIFO with count-based full/empty; a pop in the same cycle as a push
// frees the slot, so a push is accepted even when full.
module sync_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [7:0]                 wdata_i,
    input  logic                       pop_i,
    output logic [7:0]                 rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [DEPTH];
    logic          wr_en_s, rd_en_s;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        rd_en_s  = pop_i && !empty_o;
        wr_en_s  = push_i && (!full_o || rd_en_s);
        wr_ptr_d = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = rd_en_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/serial_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO; the downstream controller pops bytes
// into the registered rx_data output.
module serial_rx_fifo
    import serial_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       rx_fifo_read,
    output logic       data_in_rx_fifo,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned CPB = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int unsigned TW  = $clog2(CPB + 1);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] FULL_BIT = TW'(CPB - 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(CPB / 2 - 1);

    logic          sync1_q, sync2_q, rx_s;
    rx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          frame_err_q, frame_err_d;
    logic          overflow_q, overflow_d;
    logic          push_s, pop_s;
    logic [7:0]    fifo_rdata_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [AW:0]   fifo_count_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_s      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                timer_d = '0;
                state_d = rx_s ? RX_IDLE : RX_START;
            end
            RX_START: begin
                if (timer_q == HALF_BIT) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RX_DATA: begin
                if (timer_q == FULL_BIT) begin
                    timer_d   = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    state_d   = (bit_idx_q == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RX_STOP: begin
                // Returning to IDLE at mid-stop leaves half a bit to catch the next start edge.
                if (timer_q == FULL_BIT) begin
                    timer_d     = '0;
                    state_d     = RX_IDLE;
                    push_s      = rx_s;
                    frame_err_d = !rx_s;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = RX_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        pop_s      = rx_fifo_read && !fifo_empty_s;
        rx_data_d  = pop_s ? fifo_rdata_s : rx_data_q;
        overflow_d = push_s && fifo_full_s && !pop_s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= RX_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= rx_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_s),
        .wdata_i (shift_q),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign data_in_rx_fifo = (fifo_count_s != '0);
    assign rx_data         = rx_data_q;
    assign frame_err       = frame_err_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed and random frames against a queue-based model of the receive FIFO.
module tb_serial_rx_fifo;

    localparam int CPB      = 434;
    localparam int DEPTH    = 8;
    localparam int FRAME    = 10 * CPB;
    // two synchronizer flops, one IDLE detect cycle, half a bit, then nine full bits
    localparam int STOP_OFS = 2 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       rx_fifo_read;
    logic       data_in_rx_fifo;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_rx;

    serial_rx_fifo #(
        .CLK_FREQ_HZ (50000000),
        .BAUD        (115200),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_in           (rx_in),
        .rx_fifo_read    (rx_fifo_read),
        .data_in_rx_fifo (data_in_rx_fifo),
        .rx_data         (rx_data),
        .frame_err       (frame_err),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overflow === 1'b1)  ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives ncyc cycles of an 8N1 frame; a complete frame updates the model.
    task automatic send(input logic [7:0] b, input logic stop_val, input logic pop_stop, input int ncyc);
        int k;
        for (int c = 0; c < ncyc; c++) begin
            k = c / CPB;
            rx_in = (k == 0) ? 1'b0 : ((k < 9) ? b[k-1] : stop_val);
            rx_fifo_read = pop_stop && (c == STOP_OFS);
            @(posedge clk);
            #1;
        end
        rx_in = 1'b1;
        rx_fifo_read = 1'b0;
        if (ncyc >= FRAME) begin
            if (stop_val) begin
                if (pop_stop && exp_q.size() > 0) exp_rx = exp_q.pop_front();
                if (exp_q.size() < DEPTH) exp_q.push_back(b);
                else exp_ov++;
            end else begin
                exp_fe++;
            end
        end
    endtask

    task automatic do_pop(input string tag);
        rx_fifo_read = 1'b1;
        @(posedge clk);
        #1;
        rx_fifo_read = 1'b0;
        if (exp_q.size() > 0) exp_rx = exp_q.pop_front();
        chk(tag, rx_data, exp_rx);
        chk({tag, "_avail"}, data_in_rx_fifo, exp_q.size() != 0);
    endtask

    initial begin
        logic [7:0] rb;
        reset = 1'b1;
        rx_in = 1'b1;
        rx_fifo_read = 1'b0;
        exp_rx = 8'h00;
        idle(3);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_avail", data_in_rx_fifo, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        reset = 1'b0;
        idle(20);

        send(8'hA5, 1'b1, 1'b0, FRAME);
        chk("a5_avail", data_in_rx_fifo, 1'b1);
        chk("a5_hold", rx_data, 8'h00);
        do_pop("a5_pop");
        chk("a5_value", rx_data, 8'hA5);
        chk("a5_fe", fe_cnt, exp_fe);
        chk("a5_ov", ov_cnt, exp_ov);

        rx_in = 1'b0;
        idle(100);
        rx_in = 1'b1;
        idle(600);
        chk("glitch_avail", data_in_rx_fifo, 1'b0);
        chk("glitch_fe", fe_cnt, 0);

        send(8'h3C, 1'b0, 1'b0, FRAME);
        idle(500);
        chk("ferr_count", fe_cnt, 1);
        chk("ferr_model", fe_cnt, exp_fe);
        chk("ferr_avail", data_in_rx_fifo, 1'b0);

        for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 1'b0, FRAME);
        chk("ovf_count", ov_cnt, 1);
        chk("ovf_model", ov_cnt, exp_ov);
        chk("ovf_avail", data_in_rx_fifo, 1'b1);

        send(8'h55, 1'b1, 1'b1, FRAME);
        chk("same_cycle_ov", ov_cnt, exp_ov);
        chk("same_cycle_rx", rx_data, 8'h01);
        chk("same_cycle_avail", data_in_rx_fifo, 1'b1);
        for (int i = 0; i < DEPTH; i++) do_pop("drain");
        chk("last_out", rx_data, 8'h55);
        do_pop("empty_pop");

        send(8'hFF, 1'b1, 1'b0, 2 + CPB / 2 + 4 * CPB + CPB / 2);
        reset = 1'b1;
        idle(3);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        chk("mid_rst_avail", data_in_rx_fifo, 1'b0);
        chk("mid_rst_fe", frame_err, 1'b0);
        chk("mid_rst_ov", overflow, 1'b0);
        exp_rx = 8'h00;
        exp_q.delete();
        reset = 1'b0;
        idle(50);
        chk("post_rst_empty", data_in_rx_fifo, 1'b0);
        send(8'h12, 1'b1, 1'b0, FRAME);
        do_pop("post_rst_pop");
        chk("post_rst_value", rx_data, 8'h12);

        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            idle($urandom_range(0, 40));
            send(rb, 1'b1, 1'b0, FRAME);
        end
        for (int i = 0; i < 4; i++) do_pop("rand_pop");
        chk("final_fe", fe_cnt, exp_fe);
        chk("final_ov", ov_cnt, exp_ov);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
